// File: rtl/corepwm_pwm_gen.sv
// Per-channel PWM edge comparator with optional period-boundary shadowing of edge values.
// Optional feature macro: COREPWM_SHADOW_EN (defined = shadow_update honoured; undefined = edges load every PCLK).
module corepwm_pwm_gen #(
    parameter int APB_DWIDTH = 8,
    parameter int PWM_NUM    = 4
) (
    input  logic                          PCLK,
    input  logic                          PRESETN,
    input  logic [APB_DWIDTH-1:0]         period_cnt,
    input  logic                          sync_pulse,
    input  logic [APB_DWIDTH-1:0]         period_reg,
    input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg,
    input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg,
    input  logic [PWM_NUM-1:0]            pwm_enable,
    input  logic                          shadow_update,
    output logic [PWM_NUM-1:0]            pwm_out
);

    logic [APB_DWIDTH-1:0] act_pos [PWM_NUM];
    logic [APB_DWIDTH-1:0] act_neg [PWM_NUM];
    logic                  period_end;
    logic                  load_en;
    logic [PWM_NUM-1:0]    win_p0;

    // Unsigned window test; pos > neg describes a window that wraps through zero.
    function automatic logic in_window(input logic [APB_DWIDTH-1:0] pos,
                                       input logic [APB_DWIDTH-1:0] neg,
                                       input logic [APB_DWIDTH-1:0] cnt);
        if (pos < neg)
            return (cnt >= pos) && (cnt < neg);
        else if (pos > neg)
            return (cnt >= pos) || (cnt < neg);
        else
            return 1'b0;
    endfunction

    assign period_end = sync_pulse && (period_cnt >= period_reg);

`ifdef COREPWM_SHADOW_EN
    assign load_en = !shadow_update || period_end;
`else
    logic shadow_unused;
    assign shadow_unused = shadow_update & period_end;
    assign load_en       = 1'b1;
`endif

    // Active edge registers
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int n = 0; n < PWM_NUM; n++) begin
                act_pos[n] <= '0;
                act_neg[n] <= '0;
            end
        end else if (load_en) begin
            for (int n = 0; n < PWM_NUM; n++) begin
                act_pos[n] <= pwm_posedge_reg[n*APB_DWIDTH +: APB_DWIDTH];
                act_neg[n] <= pwm_negedge_reg[n*APB_DWIDTH +: APB_DWIDTH];
            end
        end
    end

    // Stage 0: window decode against the current count
    always_comb begin
        win_p0 = '0;
        for (int n = 0; n < PWM_NUM; n++)
            win_p0[n] = in_window(act_pos[n], act_neg[n], period_cnt) & pwm_enable[n];
    end

    // Stage 1: registered outputs
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)
            pwm_out <= '0;
        else
            pwm_out <= win_p0;
    end

endmodule

// File: tb/tb_corepwm_pwm_gen.sv
// Scoreboard bench for corepwm_pwm_gen; expected outputs are hand-derived per scenario.
// Honours COREPWM_SHADOW_EN the same way as the design build.
module tb_corepwm_pwm_gen;

    localparam int W = 8;
    localparam int N = 4;
`ifdef COREPWM_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic           PCLK = 1'b0;
    logic           PRESETN;
    logic [W-1:0]   period_cnt;
    logic           sync_pulse;
    logic [W-1:0]   period_reg;
    logic [N*W-1:0] pwm_posedge_reg;
    logic [N*W-1:0] pwm_negedge_reg;
    logic [N-1:0]   pwm_enable;
    logic           shadow_update;
    logic [N-1:0]   pwm_out;

    int checks = 0;
    int errors = 0;
    logic [N-1:0] exp_q [$];

    corepwm_pwm_gen #(.APB_DWIDTH(W), .PWM_NUM(N)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .period_cnt(period_cnt), .sync_pulse(sync_pulse),
        .period_reg(period_reg), .pwm_posedge_reg(pwm_posedge_reg),
        .pwm_negedge_reg(pwm_negedge_reg), .pwm_enable(pwm_enable),
        .shadow_update(shadow_update), .pwm_out(pwm_out)
    );

    always #5 PCLK = ~PCLK;

    task automatic set_ch(input int ch, input logic [W-1:0] p, input logic [W-1:0] q);
        pwm_posedge_reg[ch*W +: W] = p;
        pwm_negedge_reg[ch*W +: W] = q;
    endtask

    task automatic set_all(input logic [W-1:0] p, input logic [W-1:0] q);
        for (int i = 0; i < N; i++) set_ch(i, p, q);
    endtask

    // One PCLK: drive count/sync, queue the expected registered output, compare after the edge.
    task automatic drive(input string name, input logic [W-1:0] cnt, input logic sync,
                         input logic [N-1:0] exp);
        logic [N-1:0] e;
        @(negedge PCLK);
        period_cnt = cnt;
        sync_pulse = sync;
        exp_q.push_back(exp);
        @(posedge PCLK);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (pwm_out !== e) begin
            errors++;
            $display("FAIL %s cnt=%0d pwm_out=%b expected=%b", name, cnt, pwm_out, e);
        end
    endtask

    task automatic test_reset();
        PRESETN = 1'b1;
        #2 PRESETN = 1'b0;
        set_all(8'd2, 8'd6);
        pwm_enable = '1;
        for (int c = 0; c < 6; c++) begin
            drive("reset_out", W'(c * 3), 1'b1, 4'b0000);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dut.act_pos[i] !== 8'd0 || dut.act_neg[i] !== 8'd0) begin
                    errors++;
                    $display("FAIL reset_act ch=%0d act_pos=%0d act_neg=%0d expected=0", i,
                             dut.act_pos[i], dut.act_neg[i]);
                end
            end
        end
        PRESETN = 1'b1;
        drive("reset_release", 8'd0, 1'b0, 4'b0000);
    endtask

    task automatic test_normal_duty();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 10; c++)
                drive("duty", W'(c), c == 9, (c >= 2 && c <= 5) ? 4'b1111 : 4'b0000);
    endtask

    task automatic test_wrap();
        set_all(8'd7, 8'd3);
        drive("wrap_settle", 8'd0, 1'b0, 4'b0000);
        for (int c = 0; c < 10; c++)
            drive("wrap", W'(c), c == 9, (c >= 7 || c <= 2) ? 4'b1111 : 4'b0000);
        set_all(8'd4, 8'd4);
        drive("equal_settle", 8'd0, 1'b0, 4'b1111);
        for (int c = 0; c < 10; c++)
            drive("equal", W'(c), c == 9, 4'b0000);
        set_all(8'd12, 8'd15);
        drive("beyond_settle", 8'd10, 1'b0, 4'b0000);
        for (int c = 10; c < 16; c++)
            drive("beyond_period", W'(c), 1'b0, (c >= 12 && c < 15) ? 4'b1111 : 4'b0000);
    endtask

    task automatic test_shadow();
        set_all(8'd2, 8'd6);
        drive("shadow_settle", 8'd0, 1'b0, 4'b0000);
        shadow_update = 1'b1;
        for (int c = 0; c < 3; c++)
            drive("shadow_pre", W'(c), 1'b0, (c == 2) ? 4'b1111 : 4'b0000);
        for (int i = 0; i < N; i++) pwm_posedge_reg[i*W +: W] = 8'd5;
        drive("shadow_cnt3", 8'd3, 1'b0, 4'b1111);
        drive("shadow_early_sync", 8'd4, 1'b1, SH ? 4'b1111 : 4'b0000);
        drive("shadow_cnt5", 8'd5, 1'b0, 4'b1111);
        for (int c = 6; c < 10; c++)
            drive("shadow_tail", W'(c), c == 9, 4'b0000);
        for (int c = 0; c < 10; c++)
            drive("shadow_new", W'(c), c == 9, (c == 5) ? 4'b1111 : 4'b0000);
        set_all(8'd3, 8'd6);
        shadow_update = 1'b0;
        drive("shadow_off_old", 8'd1, 1'b0, 4'b0000);
        drive("shadow_off_new", 8'd3, 1'b0, 4'b1111);
    endtask

    function automatic logic [N-1:0] mixed_exp(input int c);
        logic [N-1:0] e;
        e[2:0] = (c >= 2 && c <= 5) ? 3'b111 : 3'b000;
        e[3]   = (c >= 7 || c <= 2);
        return e;
    endfunction

    task automatic test_enable();
        set_all(8'd2, 8'd6);
        set_ch(3, 8'd7, 8'd3);
        drive("enable_settle", 8'd0, 1'b0, 4'b0000);
        for (int c = 0; c < 4; c++)
            drive("mixed", W'(c), 1'b0, mixed_exp(c));
        pwm_enable = 4'b1101;
        for (int c = 4; c < 10; c++)
            drive("ch1_disabled", W'(c), c == 9, mixed_exp(c) & 4'b1101);
        checks++;
        if (dut.act_pos[1] !== 8'd2 || dut.act_neg[1] !== 8'd6) begin
            errors++;
            $display("FAIL enable_act ch1 act_pos=%0d act_neg=%0d expected=2/6",
                     dut.act_pos[1], dut.act_neg[1]);
        end
        pwm_enable = 4'b1111;
        for (int c = 0; c < 5; c++)
            drive("reenabled", W'(c), 1'b0, mixed_exp(c));
    endtask

    task automatic test_reset_mid();
        shadow_update = 1'b1;
        set_all(8'd1, 8'd8);
        PRESETN = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_out pwm_out=%b expected=0000", pwm_out);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut.act_pos[i] !== 8'd0 || dut.act_neg[i] !== 8'd0) begin
                errors++;
                $display("FAIL reset_mid_act ch=%0d act_pos=%0d act_neg=%0d expected=0", i,
                         dut.act_pos[i], dut.act_neg[i]);
            end
        end
        drive("reset_mid_held", 8'd4, 1'b0, 4'b0000);
        PRESETN = 1'b1;
        drive("post_reset_5", 8'd5, 1'b0, 4'b0000);
        drive("post_reset_6", 8'd6, 1'b0, SH ? 4'b0000 : 4'b1111);
        drive("post_reset_end", 8'd9, 1'b1, 4'b0000);
        drive("post_reset_next", 8'd2, 1'b0, 4'b1111);
        shadow_update = 1'b0;
    endtask

    initial begin
        period_cnt      = '0;
        sync_pulse      = 1'b0;
        period_reg      = 8'd9;
        pwm_posedge_reg = '0;
        pwm_negedge_reg = '0;
        pwm_enable      = '0;
        shadow_update   = 1'b0;
        test_reset();
        test_normal_duty();
        test_wrap();
        test_shadow();
        test_enable();
        drive("pre_reset_mid", 8'd4, 1'b0, mixed_exp(4));
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
